// File: rtl/mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// mp_add_sequencer
//   Multi-precision add controller. It steps one shared external 8-bit adder
//   across WORDS byte lanes, least significant lane first. A register carries
//   the carry from one lane to the next.
//
//   Optional feature: define MP_ADD_SUBTRACT_EN to add the op_sub port. When
//   op_sub=1 the block computes A-B: B is inverted at capture and the initial
//   carry is forced to 1.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               command strobe, only sampled while idle
//   op_a, op_b, cin     operands and carry-in, captured on an accepted start
//   op_sub              (MP_ADD_SUBTRACT_EN only) subtract select, captured on start
//   busy                high while lanes are being processed
//   done                one-cycle pulse; result/cout are valid from this cycle
//   result, cout        (8*WORDS)-bit sum and final carry-out
//   add_a/b/cin         drive to the external adder (zero while idle)
//   add_sum, add_cout   combinational response from the external adder
// ---------------------------------------------------------------------------
module mp_add_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic                 cin,
`ifdef MP_ADD_SUBTRACT_EN
    input  logic                 op_sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [8*WORDS-1:0]   result,
    output logic                 cout,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    output logic                 add_cin,
    input  logic [7:0]           add_sum,
    input  logic                 add_cout
);

    // Lane index is at least 1 bit wide; with WORDS=1 it never leaves 0.
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [8*WORDS-1:0] r_a;
    logic [8*WORDS-1:0] r_b;
    logic               r_carry;
    logic [8*WORDS-1:0] r_result;
    logic               r_cout;
    logic               r_done;

    logic               w_sub;
    logic [7:0]         w_lane_a;
    logic [7:0]         w_lane_b;

`ifdef MP_ADD_SUBTRACT_EN
    assign w_sub = op_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Sequencer: state, lane index, captured operands and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= op_a;
                        // Subtraction is A + ~B + 1.
                        r_b     <= w_sub ? ~op_b : op_b;
                        r_carry <= w_sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int w = 0; w < int'(WORDS); w++) begin
                        if (r_idx == IDX_W'(w)) begin
                            r_result[8*w +: 8] <= add_sum;
                        end
                    end
                    r_carry <= add_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= add_cout;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Lane select for the adder operands.
    always_comb begin
        w_lane_a = 8'h00;
        w_lane_b = 8'h00;
        for (int w = 0; w < int'(WORDS); w++) begin
            if (r_idx == IDX_W'(w)) begin
                w_lane_a = r_a[8*w +: 8];
                w_lane_b = r_b[8*w +: 8];
            end
        end
    end

    assign add_a   = (r_state == ST_RUN) ? w_lane_a : 8'h00;
    assign add_b   = (r_state == ST_RUN) ? w_lane_b : 8'h00;
    assign add_cin = (r_state == ST_RUN) ? r_carry  : 1'b0;

    assign busy   = (r_state == ST_RUN);
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_cout;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mp_add_sequencer
//   Directed bench for mp_add_sequencer. It instantiates a WORDS=4 DUT and a
//   WORDS=1 DUT, each with a behavioural 8-bit adder beside it. The bench
//   drives inputs 1 time unit after the rising edge and samples there too.
//   Define MP_ADD_SUBTRACT_EN to exercise the op_sub port as well.
// ---------------------------------------------------------------------------
module tb_mp_add_sequencer;

    logic        clk;
    logic        rst_n;

    // WORDS=4 instance
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;
    logic        op_sub;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    // WORDS=1 instance
    logic        start1;
    logic [7:0]  op_a1;
    logic [7:0]  op_b1;
    logic        busy1;
    logic        done1;
    logic [7:0]  result1;
    logic        cout1;
    logic [7:0]  add_a1;
    logic [7:0]  add_b1;
    logic        add_cin1;
    logic [7:0]  add_sum1;
    logic        add_cout1;

    int n_checks;
    int n_errors;
    int done_cnt;
    int lat;
    int prev_cnt;

    // Behavioural models of the external parallel adder.
    assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'h00, add_cin1};

    mp_add_sequencer #(.WORDS(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
`ifdef MP_ADD_SUBTRACT_EN
        .op_sub   (op_sub),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    mp_add_sequencer #(.WORDS(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .op_a     (op_a1),
        .op_b     (op_b1),
        .cin      (1'b0),
`ifdef MP_ADD_SUBTRACT_EN
        .op_sub   (1'b0),
`endif
        .busy     (busy1),
        .done     (done1),
        .result   (result1),
        .cout     (cout1),
        .add_a    (add_a1),
        .add_b    (add_b1),
        .add_cin  (add_cin1),
        .add_sum  (add_sum1),
        .add_cout (add_cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the WORDS=4 DUT; lat counts edges after the call.
    task automatic wait_done(input string tag, output int l);
        bit seen;
        seen = 1'b0;
        l = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            l++;
            if (done) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Issue one command and wait for done.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, output int l);
        op_a   = a;
        op_b   = b;
        cin    = c;
        op_sub = s;
        start  = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(tag, l);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        cin    = 1'b0;
        op_sub = 1'b0;
        start1 = 1'b0;
        op_a1  = '0;
        op_b1  = '0;
        #12;
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_result", result,          32'd0);
        check("rst_cout",   {31'd0, cout},   32'd0);
        check("rst_add_a",  {24'd0, add_a},  32'd0);
        check("rst_add_cin",{31'd0, add_cin},32'd0);
        rst_n = 1'b1;
        step();

        // 1: single carry into lane 1
        run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
        check("t1_lat",    lat, 32'd4);
        check("t1_result", result, 32'h0000_0100);
        check("t1_cout",   {31'd0, cout}, 32'd0);
        step();
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_idle_add_b", {24'd0, add_b}, 32'd0);

        // 2: full ripple across all lanes
        run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, lat);
        check("t2_result", result, 32'h0000_0000);
        check("t2_cout",   {31'd0, cout}, 32'd1);
        step();

        // 3: second start while busy is ignored
        prev_cnt = done_cnt;
        op_a = 32'h0101_0101; op_b = 32'h0202_0202; cin = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_lane0_a", {24'd0, add_a}, 32'h0000_0001);
        step();
        op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; cin = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        check("t3_done_count", done_cnt - prev_cnt, 32'd1);
        check("t3_result", result, 32'h0303_0303);
        check("t3_cout",   {31'd0, cout}, 32'd0);

        // 4: reset while lane 2 is in progress
        prev_cnt = done_cnt;
        op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001; cin = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #2;
        check("t4_rst_busy",   {31'd0, busy}, 32'd0);
        check("t4_rst_result", result, 32'd0);
        check("t4_rst_done",   {31'd0, done}, 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (8) step();
        check("t4_no_done", done_cnt - prev_cnt, 32'd0);
        check("t4_idle_result", result, 32'd0);
        run_op("t4", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
        check("t4_result", result, 32'h2345_6789);
        check("t4_cout",   {31'd0, cout}, 32'd0);
        step();

        // 5: start held across the done cycle is accepted there
        op_a = 32'h0000_FFFF; op_b = 32'h0000_0001; cin = 1'b0;
        start = 1'b1;
        step();
        wait_done("t5a", lat);
        check("t5a_lat",    lat, 32'd4);
        check("t5a_result", result, 32'h0001_0000);
        op_a = 32'h8000_0000; op_b = 32'h8000_0000;
        step();
        start = 1'b0;
        check("t5_accept_busy", {31'd0, busy}, 32'd1);
        wait_done("t5b", lat);
        check("t5b_lat",    lat, 32'd4);
        check("t5b_result", result, 32'h0000_0000);
        check("t5b_cout",   {31'd0, cout}, 32'd1);
        step();

`ifdef MP_ADD_SUBTRACT_EN
        // 6a: 5 - 7 wraps with a borrow
        run_op("t6", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, lat);
        check("t6_result", result, 32'hFFFF_FFFE);
        check("t6_cout",   {31'd0, cout}, 32'd0);
        step();
        op_sub = 1'b0;
`endif

        // 6b: WORDS=1, latency 1
        op_a1 = 8'h80; op_b1 = 8'h80;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("w1_busy", {31'd0, busy1}, 32'd1);
        check("w1_add_a", {24'd0, add_a1}, 32'h0000_0080);
        step();
        check("w1_done",   {31'd0, done1}, 32'd1);
        check("w1_result", {24'd0, result1}, 32'd0);
        check("w1_cout",   {31'd0, cout1}, 32'd1);
        check("w1_idle",   {31'd0, busy1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
